ball_collision: RTL and testbench

BALL_COLLISION -- requirements
Module: ball_collision

---
 rtl/pong_pkg.sv | 27 ++
 rtl/paddle_hit.sv | 52 +++++
 rtl/ball_collision.sv | 210 +++++++++++++++++++++
 tb/tb_ball_collision.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared FSM state encoding, default playfield geometry and a saturating
// increment helper for the pong collision logic.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int DEF_SCREEN_W       = 640;
    localparam int DEF_SCREEN_H       = 480;
    localparam int DEF_BALL_SIZE      = 8;
    localparam int DEF_PADDLE_W       = 8;
    localparam int DEF_PADDLE_H       = 64;
    localparam int DEF_LEFT_PADDLE_X  = 16;
    localparam int DEF_RIGHT_PADDLE_X = 616;
    localparam int DEF_SERVE_DELAY    = 60;
    localparam int DEF_MAX_VEL        = 8;
    localparam int DEF_WIN_SCORE      = 9;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max_v);
        return (v >= max_v) ? max_v : v + 4'd1;
    endfunction

endpackage

// File: rtl/paddle_hit.sv
// Overlap test between the proposed ball square and one paddle, plus the
// ball-centre offset classification used for spin. Coordinates are 11 bits.
module paddle_hit
    import pong_pkg::*;
#(
    parameter int PADDLE_X  = DEF_LEFT_PADDLE_X,
    parameter int PADDLE_W  = DEF_PADDLE_W,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter bit IS_RIGHT  = 1'b0
) (
    input  logic [10:0] ball_x_i,
    input  logic [10:0] ball_y_i,
    input  logic [10:0] paddle_y_i,
    output logic        hit_o,
    output logic        spin_o,
    output logic        spin_down_o
);

    localparam logic [10:0] PX      = 11'(PADDLE_X);
    localparam logic [10:0] PW      = 11'(PADDLE_W);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] HALF_BS = 11'(BALL_SIZE / 2);
    localparam logic [10:0] HALF_PH = 11'(PADDLE_H / 2);
    localparam logic [10:0] QTR_PH  = 11'(PADDLE_H / 4);

    logic        horiz;
    logic        vert;
    logic [10:0] ball_c;
    logic [10:0] pad_c;
    logic [10:0] off_mag;

    // The hitting face is the paddle's inner edge, so the inclusive bound flips side.
    generate
        if (IS_RIGHT) begin : g_right
            assign horiz = (ball_x_i + BS >= PX) && (ball_x_i < PX + PW);
        end else begin : g_left
            assign horiz = (ball_x_i <= PX + PW) && (ball_x_i + BS > PX);
        end
    endgenerate

    assign vert  = (ball_y_i + BS > paddle_y_i) && (ball_y_i < paddle_y_i + PH);
    assign hit_o = horiz && vert;

    assign ball_c      = ball_y_i + HALF_BS;
    assign pad_c       = paddle_y_i + HALF_PH;
    assign spin_down_o = ball_c > pad_c;
    assign off_mag     = spin_down_o ? (ball_c - pad_c) : (pad_c - ball_c);
    assign spin_o      = off_mag >= QTR_PH;

endmodule

// File: rtl/ball_collision.sv
// Pong ball collision / scoring FSM: commits the mover's proposed position once
// per frame_tick, clamping at walls and paddles. Define BALL_SPIN_EN for paddle spin.
module ball_collision
    import pong_pkg::*;
#(
    parameter int SCREEN_W       = DEF_SCREEN_W,
    parameter int SCREEN_H       = DEF_SCREEN_H,
    parameter int BALL_SIZE      = DEF_BALL_SIZE,
    parameter int PADDLE_W       = DEF_PADDLE_W,
    parameter int PADDLE_H       = DEF_PADDLE_H,
    parameter int LEFT_PADDLE_X  = DEF_LEFT_PADDLE_X,
    parameter int RIGHT_PADDLE_X = DEF_RIGHT_PADDLE_X,
    parameter int SERVE_DELAY    = DEF_SERVE_DELAY,
    parameter int MAX_VEL        = DEF_MAX_VEL,
    parameter int WIN_SCORE      = DEF_WIN_SCORE
) (
    input  logic       game_clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [9:0] next_x_ball,
    input  logic [9:0] next_y_ball,
    input  logic [9:0] left_paddle_y,
    input  logic [9:0] right_paddle_y,
    output logic [9:0] cur_x_ball,
    output logic [9:0] cur_y_ball,
    output logic [3:0] x_ball_vel,
    output logic [3:0] y_ball_vel,
    output logic       x_ball_dir,
    output logic       y_ball_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       ball_visible
);

    localparam logic [10:0] SW     = 11'(SCREEN_W);
    localparam logic [10:0] SH     = 11'(SCREEN_H);
    localparam logic [10:0] BS     = 11'(BALL_SIZE);
    localparam logic [9:0]  CX0    = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CY0    = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_BOT  = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  X_LHIT = 10'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [9:0]  X_RHIT = 10'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [3:0]  VMAX   = 4'(MAX_VEL);
    localparam logic [3:0]  WIN    = 4'(WIN_SCORE);
    localparam int          CNT_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [3:0]       xv_q, xv_d, yv_q, yv_d;
    logic             xd_q, xd_d, yd_q, yd_d;
    logic [3:0]       sl_q, sl_d, sr_q, sr_d;
    logic             go_q, go_d, vis_q, vis_d;

    logic [10:0] nx, ny, lp, rp;
    logic        l_hit, l_spin, l_down, r_hit, r_spin, r_down;
    logic        hit_l, hit_r;

    assign nx = {1'b0, next_x_ball};
    assign ny = {1'b0, next_y_ball};
    assign lp = {1'b0, left_paddle_y};
    assign rp = {1'b0, right_paddle_y};

    paddle_hit #(
        .PADDLE_X(LEFT_PADDLE_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
        .BALL_SIZE(BALL_SIZE), .IS_RIGHT(1'b0)
    ) u_left (
        .ball_x_i(nx), .ball_y_i(ny), .paddle_y_i(lp),
        .hit_o(l_hit), .spin_o(l_spin), .spin_down_o(l_down)
    );

    paddle_hit #(
        .PADDLE_X(RIGHT_PADDLE_X), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H),
        .BALL_SIZE(BALL_SIZE), .IS_RIGHT(1'b1)
    ) u_right (
        .ball_x_i(nx), .ball_y_i(ny), .paddle_y_i(rp),
        .hit_o(r_hit), .spin_o(r_spin), .spin_down_o(r_down)
    );

    // Only the paddle the ball is travelling toward can be hit.
    assign hit_l = ~xd_q & l_hit;
    assign hit_r =  xd_q & r_hit;

`ifndef BALL_SPIN_EN
    logic unused_spin;
    assign unused_spin = ^{l_spin, l_down, r_spin, r_down};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        xv_d    = xv_q;
        yv_d    = yv_q;
        xd_d    = xd_q;
        yd_d    = yd_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        go_d    = go_q;
        vis_d   = vis_q;
        if (frame_tick) begin
            unique case (state_q)
                ST_SERVE: begin
                    // x_dir is left as it was at the miss, i.e. toward the loser.
                    if (cnt_q == CNT_LAST) begin
                        x_d     = CX0;
                        y_d     = CY0;
                        xv_d    = 4'd2;
                        yv_d    = 4'd1;
                        vis_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    x_d = next_x_ball;
                    y_d = next_y_ball;
`ifdef BALL_SPIN_EN
                    if ((hit_l && l_spin) || (hit_r && r_spin)) begin
                        yv_d = sat_inc(yv_q, VMAX);
                        yd_d = hit_l ? l_down : r_down;
                    end
`endif
                    // A wrapped coordinate (>= SCREEN_H) means the ball crossed the top.
                    if (!yd_q && (ny == '0 || ny >= SH)) begin
                        y_d  = '0;
                        yd_d = 1'b1;
                    end else if (yd_q && (ny + BS >= SH)) begin
                        y_d  = Y_BOT;
                        yd_d = 1'b0;
                    end
                    if (hit_l) begin
                        x_d  = X_LHIT;
                        xd_d = 1'b1;
                        xv_d = sat_inc(xv_q, VMAX);
                    end else if (hit_r) begin
                        x_d  = X_RHIT;
                        xd_d = 1'b0;
                        xv_d = sat_inc(xv_q, VMAX);
                    end else if (!xd_q && (nx >= SW || nx == '0)) begin
                        sr_d    = sr_q + 4'd1;
                        vis_d   = 1'b0;
                        state_d = ST_POINT;
                    end else if (xd_q && (nx + BS >= SW)) begin
                        sl_d    = sl_q + 4'd1;
                        vis_d   = 1'b0;
                        state_d = ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (sl_q == WIN || sr_q == WIN) begin
                        go_d    = 1'b1;
                        state_d = ST_OVER;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SERVE;
                    end
                end
                ST_OVER: ;
            endcase
        end
    end

    always_ff @(posedge game_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SERVE;
            cnt_q   <= '0;
            x_q     <= CX0;
            y_q     <= CY0;
            xv_q    <= '0;
            yv_q    <= '0;
            xd_q    <= 1'b1;
            yd_q    <= 1'b1;
            sl_q    <= '0;
            sr_q    <= '0;
            go_q    <= 1'b0;
            vis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xv_q    <= xv_d;
            yv_q    <= yv_d;
            xd_q    <= xd_d;
            yd_q    <= yd_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            go_q    <= go_d;
            vis_q   <= vis_d;
        end
    end

    assign cur_x_ball   = x_q;
    assign cur_y_ball   = y_q;
    assign x_ball_vel   = xv_q;
    assign y_ball_vel   = yv_q;
    assign x_ball_dir   = xd_q;
    assign y_ball_dir   = yd_q;
    assign score_left   = sl_q;
    assign score_right  = sr_q;
    assign game_over    = go_q;
    assign ball_visible = vis_q;

endmodule

// File: tb/tb_ball_collision.sv
// Randomized bench for ball_collision: a ball-mover/paddle driver feeds a
// behavioural game model whose expected outputs are checked by a separate monitor.
module tb_ball_collision;

    localparam int SW = 640, SH = 480, BS = 8, PW = 8, PH = 64;
    localparam int LX = 16, RX = 616, SD = 60, VMAX = 8, WIN = 9;
    localparam int M_SERVE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;

    logic       game_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] next_x_ball = '0, next_y_ball = '0;
    logic [9:0] left_paddle_y = '0, right_paddle_y = '0;
    logic [9:0] cur_x_ball, cur_y_ball;
    logic [3:0] x_ball_vel, y_ball_vel;
    logic       x_ball_dir, y_ball_dir;
    logic [3:0] score_left, score_right;
    logic       game_over, ball_visible;

    ball_collision dut (
        .game_clk(game_clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .next_x_ball(next_x_ball), .next_y_ball(next_y_ball),
        .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
        .cur_x_ball(cur_x_ball), .cur_y_ball(cur_y_ball),
        .x_ball_vel(x_ball_vel), .y_ball_vel(y_ball_vel),
        .x_ball_dir(x_ball_dir), .y_ball_dir(y_ball_dir),
        .score_left(score_left), .score_right(score_right),
        .game_over(game_over), .ball_visible(ball_visible)
    );

    always #5 game_clk = ~game_clk;

    typedef struct {
        int x, y, xv, yv, xd, yd, sl, sr, go, vis;
    } obs_t;

    // Game model state
    int m_mode, m_wait, m_x, m_y, m_xv, m_yv, m_xd, m_yd, m_sl, m_sr, m_go, m_vis;
    int need_pick = 1, leg_dir = 0, track = 1;

    obs_t sb_q[$];
    obs_t last;
    int   n_chk = 0, n_pass = 0;
    bit   mon_en = 1'b0;
    logic tick_d = 1'b0;

    function automatic obs_t model_obs();
        obs_t o;
        o.x = m_x; o.y = m_y; o.xv = m_xv; o.yv = m_yv; o.xd = m_xd; o.yd = m_yd;
        o.sl = m_sl; o.sr = m_sr; o.go = m_go; o.vis = m_vis;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.x = cur_x_ball; o.y = cur_y_ball; o.xv = x_ball_vel; o.yv = y_ball_vel;
        o.xd = x_ball_dir; o.yd = y_ball_dir; o.sl = score_left; o.sr = score_right;
        o.go = game_over; o.vis = ball_visible;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d xv=%0d yv=%0d xd=%0d yd=%0d sl=%0d sr=%0d go=%0d vis=%0d",
                         o.x, o.y, o.xv, o.yv, o.xd, o.yd, o.sl, o.sr, o.go, o.vis);
    endfunction

    task automatic check(input obs_t e, input string nm);
        string sa, se;
        sa = fmt(dut_obs());
        se = fmt(e);
        n_chk++;
        if (sa == se) n_pass++;
        else $display("FAIL %s t=%0t got {%s} expected {%s}", nm, $time, sa, se);
    endtask

    function automatic void model_reset();
        m_mode = M_SERVE; m_wait = 0;
        m_x = (SW - BS) / 2; m_y = (SH - BS) / 2;
        m_xv = 0; m_yv = 0; m_xd = 1; m_yd = 1;
        m_sl = 0; m_sr = 0; m_go = 0; m_vis = 0;
        need_pick = 1;
    endfunction

    function automatic int inc_sat(int v);
        return (v + 1 > VMAX) ? VMAX : v + 1;
    endfunction

    // One frame of the game rules, from the current model state.
    task automatic model_tick(input int nx, input int ny, input int lp, input int rp);
        bit lh, rh;
        int old_xd, old_yd;
        case (m_mode)
            M_SERVE: begin
                m_wait++;
                if (m_wait == SD) begin
                    m_x = (SW - BS) / 2; m_y = (SH - BS) / 2;
                    m_xv = 2; m_yv = 1; m_vis = 1; m_mode = M_PLAY;
                end
            end
            M_PLAY: begin
                old_xd = m_xd; old_yd = m_yd;
                lh = (old_xd == 0) && nx <= LX + PW && nx + BS > LX && ny + BS > lp && ny < lp + PH;
                rh = (old_xd == 1) && nx + BS >= RX && nx < RX + PW && ny + BS > rp && ny < rp + PH;
                m_x = nx; m_y = ny;
`ifdef BALL_SPIN_EN
                if (lh || rh) begin
                    int pad, off;
                    pad = lh ? lp : rp;
                    off = (ny + BS / 2) - (pad + PH / 2);
                    if (off >= PH / 4 || -off >= PH / 4) begin
                        m_yv = inc_sat(m_yv);
                        m_yd = (off > 0) ? 1 : 0;
                    end
                end
`endif
                if (old_yd == 0 && (ny == 0 || ny >= SH)) begin
                    m_y = 0; m_yd = 1;
                end else if (old_yd == 1 && ny + BS >= SH) begin
                    m_y = SH - BS; m_yd = 0;
                end
                if (lh) begin
                    m_x = LX + PW; m_xd = 1; m_xv = inc_sat(m_xv);
                end else if (rh) begin
                    m_x = RX - BS; m_xd = 0; m_xv = inc_sat(m_xv);
                end else if (old_xd == 0 && (nx >= SW || nx == 0)) begin
                    m_sr++; m_mode = M_POINT; m_vis = 0;
                end else if (old_xd == 1 && nx + BS >= SW) begin
                    m_sl++; m_mode = M_POINT; m_vis = 0;
                end
            end
            M_POINT: begin
                if (m_sl == WIN || m_sr == WIN) begin
                    m_mode = M_OVER; m_go = 1;
                end else begin
                    m_mode = M_SERVE; m_wait = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge; acts as ball mover plus two paddle players.
    task automatic do_tick();
        int vx, vy, nx, ny, lp, rp, r;
        vx = m_xd ? m_xv : -m_xv;
        vy = m_yd ? m_yv : -m_yv;
        nx = (m_x + vx + 1024) % 1024;
        ny = (m_y + vy + 1024) % 1024;
        if ($urandom_range(0, 15) == 0) begin r = $urandom_range(0, 6); nx = (nx + r + 1021) % 1024; end
        if ($urandom_range(0, 15) == 0) begin r = $urandom_range(0, 6); ny = (ny + r + 1021) % 1024; end
        if (m_mode != M_PLAY) need_pick = 1;
        else if (need_pick != 0 || m_xd != leg_dir) begin
            track = ($urandom_range(0, 3) != 0) ? 1 : 0;
            leg_dir = m_xd;
            need_pick = 0;
        end
        if (track != 0) begin
            r = $urandom_range(0, 63); lp = (ny - r < 0) ? 0 : ny - r;
            r = $urandom_range(0, 63); rp = (ny - r < 0) ? 0 : ny - r;
        end else begin
            lp = (ny < 200) ? 300 : 0;
            rp = lp;
        end
        frame_tick = 1'b1;
        next_x_ball = 10'(nx); next_y_ball = 10'(ny);
        left_paddle_y = 10'(lp); right_paddle_y = 10'(rp);
        model_tick(nx, ny, lp, rp);
        sb_q.push_back(model_obs());
        @(negedge game_clk);
        frame_tick = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge game_clk);
    endtask

    task automatic run(input int n_max, input bit stop_over);
        int over_n;
        over_n = 0;
        for (int i = 0; i < n_max; i++) begin
            do_tick();
            if (m_mode == M_OVER) over_n++;
            if (stop_over && over_n > 20) break;
        end
    endtask

    // Reset lands between clock edges so the check proves it is asynchronous.
    task automatic apply_reset(input string nm);
        frame_tick = 1'b0;
        @(negedge game_clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        last = model_obs();
        check(last, nm);
        @(negedge game_clk);
        @(negedge game_clk);
        rst_n = 1'b1;
    endtask

    always @(posedge game_clk) tick_d <= frame_tick;

    initial begin
        forever begin
            @(negedge game_clk);
            if (tick_d) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow t=%0t got output update expected none queued", $time);
                end else begin
                    last = sb_q.pop_front();
                    check(last, "tick");
                end
            end else if (mon_en) begin
                check(last, "hold");
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        last = model_obs();
        check(last, "reset");
        mon_en = 1'b1;
        @(negedge game_clk);
        @(negedge game_clk);
        rst_n = 1'b1;
        run(12000, 1'b1);
        apply_reset("reset_after_game");
        run(700, 1'b0);
        apply_reset("reset_midplay");
        run(12000, 1'b1);
        repeat (3) @(negedge game_clk);
        n_chk++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain got %0d pending expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
